// File: rtl/nn_sng_pkg.sv
// Shared constants for the weight stochastic-number generator: default sizes,
// FSM state encoding, per-channel LFSR seeds and maximal-length tap masks.
package nn_sng_pkg;

    localparam int SNG_N_DEFAULT = 3;
    localparam int SNG_W_DEFAULT = 8;

    typedef enum logic {
        ST_OPEN    = 1'b0,
        ST_PENDING = 1'b1
    } ld_state_e;

    // Feedback mask for a shift-left Fibonacci LFSR; bit k set means state[k] feeds the XOR.
    // W=8 gives taps 8,6,5,4 (x^8+x^6+x^5+x^4+1).
    function automatic logic [31:0] tap_mask(input int w);
        logic [31:0] m;
        case (w)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            default: m = 32'h0000_00B8;
        endcase
        return m;
    endfunction

    // Seed table, one entry per channel; the low bytes are distinct and nonzero
    // so every channel starts at a different point of the sequence.
    function automatic logic [31:0] seed_of(input int idx, input int w);
        logic [31:0] v;
        logic [31:0] m;
        case (idx)
            0:       v = 32'h0000_B5E1;
            1:       v = 32'h0000_3C27;
            2:       v = 32'h0000_9A4D;
            3:       v = 32'h0000_6E93;
            4:       v = 32'h0000_1F5B;
            5:       v = 32'h0000_D2C8;
            6:       v = 32'h0000_47B6;
            7:       v = 32'h0000_A83F;
            8:       v = 32'h0000_2D71;
            9:       v = 32'h0000_F30A;
            10:      v = 32'h0000_8C64;
            11:      v = 32'h0000_51D9;
            12:      v = 32'h0000_E7A2;
            13:      v = 32'h0000_0B3C;
            14:      v = 32'h0000_7694;
            15:      v = 32'h0000_C85F;
            default: v = (32'(idx) * 32'h0000_9E37) + 32'h1;
        endcase
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        v = v & m;
        if (v == 32'h0) begin
            v = 32'h1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sng_channel.sv
// One stochastic channel: maximal-length LFSR, compare against the weight,
// registered output bit that is forced low while disabled.
module sng_channel
    import nn_sng_pkg::*;
#(
    parameter int W   = SNG_W_DEFAULT,
    parameter int IDX = 0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_weight,
    output logic         o_bit
);

    localparam logic [31:0]  SEED_FULL = seed_of(IDX, W);
    localparam logic [31:0]  TAP_FULL  = tap_mask(W);
    localparam logic [W-1:0] SEED      = SEED_FULL[W-1:0];
    localparam logic [W-1:0] TAPS      = TAP_FULL[W-1:0];

    logic [W-1:0] r_lfsr;
    logic         r_bit;
    logic         w_fb;
    logic         w_cmp;

    assign w_fb  = ^(r_lfsr & TAPS);
    assign w_cmp = (r_lfsr <= i_weight);

    // The LFSR never visits zero, so over one period the compare is true for exactly i_weight states.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
            r_bit  <= 1'b0;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[W-2:0], w_fb};
            r_bit  <= w_cmp;
        end else begin
            r_bit  <= 1'b0;
        end
    end

    assign o_bit = r_bit;

endmodule

// File: rtl/nn_weight_sng.sv
// Weight/bias bitstream generator: N+1 LFSR channels with shadow/active weight
// banks; commits taken while running are deferred to the period boundary.
module nn_weight_sng
    import nn_sng_pkg::*;
#(
    parameter  int N  = SNG_N_DEFAULT,
    parameter  int W  = SNG_W_DEFAULT,
    localparam int IW = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          EN,
    input  logic          LD_VALID,
    input  logic [IW-1:0] LD_IDX,
    input  logic [W-1:0]  LD_DATA,
    input  logic          LD_COMMIT,
    output logic          LD_READY,
    output logic [N-1:0]  alpha,
    output logic          beta,
    output logic          PERIOD_DONE
);

    localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

    ld_state_e    r_state;
    ld_state_e    w_next_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_shadow      [N+1];
    logic [W-1:0] r_active      [N+1];
    logic [W-1:0] w_shadow_next [N+1];
    logic         w_ready;
    logic         w_write;
    logic         w_commit;
    logic         w_period_done;
    logic [N:0]   w_bits;

    assign w_period_done = EN && (r_cnt == CNT_LAST);
    assign w_write       = LD_VALID && w_ready;

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A commit while stopped applies at once; while running it waits for the
    // period boundary, or for the first stopped cycle if EN drops first.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_OPEN: begin
                w_ready = 1'b1;
                if (LD_COMMIT) begin
                    if (EN) begin
                        w_next_state = ST_PENDING;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
            end
            ST_PENDING: begin
                if (!EN || w_period_done) begin
                    w_commit     = 1'b1;
                    w_next_state = ST_OPEN;
                end
            end
            default: w_next_state = ST_OPEN;
        endcase
    end

    // Indices above N match no entry, so those writes fall away.
    always_comb begin
        for (int i = 0; i <= N; i++) begin
            w_shadow_next[i] = r_shadow[i];
            if (w_write && (LD_IDX == IW'(i))) begin
                w_shadow_next[i] = LD_DATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            for (int i = 0; i <= N; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= N; i++) begin
                r_shadow[i] <= w_shadow_next[i];
                if (w_commit) begin
                    r_active[i] <= w_shadow_next[i];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            r_cnt <= '0;
        end else if (EN) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : (r_cnt + W'(1));
        end
    end

    for (genvar gi = 0; gi <= N; gi++) begin : g_ch
        sng_channel #(
            .W   (W),
            .IDX (gi)
        ) u_ch (
            .i_clk    (CLK),
            .i_rst_n  (INIT),
            .i_en     (EN),
            .i_weight (r_active[gi]),
            .o_bit    (w_bits[gi])
        );
    end

    assign alpha       = w_bits[N-1:0];
    assign beta        = w_bits[N];
    assign LD_READY    = w_ready;
    assign PERIOD_DONE = w_period_done;

endmodule

// File: tb/tb_nn_weight_sng.sv
// Bench for nn_weight_sng: directed weight loads and commits; a monitor sums
// the ones of every 255-cycle period and checks them against queued counts.
module tb_nn_weight_sng;

    localparam int N = 3;
    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       INIT;
    logic       EN;
    logic       LD_VALID;
    logic [1:0] LD_IDX;
    logic [7:0] LD_DATA;
    logic       LD_COMMIT;
    logic       LD_READY;
    logic [2:0] alpha;
    logic       beta;
    logic       PERIOD_DONE;

    int n_checks = 0;
    int n_errors = 0;
    int pd_total = 0;
    int acc_a0   = 0;
    int acc_a1   = 0;
    int acc_a2   = 0;
    int acc_b    = 0;
    logic pd_armed = 1'b0;
    logic [31:0] exp_q[$];

    nn_weight_sng #(.N(N), .W(W)) dut (
        .CLK         (CLK),
        .INIT        (INIT),
        .EN          (EN),
        .LD_VALID    (LD_VALID),
        .LD_IDX      (LD_IDX),
        .LD_DATA     (LD_DATA),
        .LD_COMMIT   (LD_COMMIT),
        .LD_READY    (LD_READY),
        .alpha       (alpha),
        .beta        (beta),
        .PERIOD_DONE (PERIOD_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int b);
        logic [31:0] v;
        v = {a0[7:0], a1[7:0], a2[7:0], b[7:0]};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_w(input int idx, input int data);
        LD_VALID = 1'b1;
        LD_IDX   = idx[1:0];
        LD_DATA  = data[7:0];
        step();
        LD_VALID = 1'b0;
    endtask

    // Period monitor: the output registered on the PERIOD_DONE edge is the
    // last bit of the period, so the tally closes one sample after the pulse.
    always @(negedge CLK) begin
        logic [31:0] got;
        logic [31:0] exp;
        if (!INIT) begin
            acc_a0   = 0;
            acc_a1   = 0;
            acc_a2   = 0;
            acc_b    = 0;
            pd_armed = 1'b0;
        end else begin
            acc_a0 += int'(alpha[0]);
            acc_a1 += int'(alpha[1]);
            acc_a2 += int'(alpha[2]);
            acc_b  += int'(beta);
            if (pd_armed) begin
                got = pack4(acc_a0, acc_a1, acc_a2, acc_b);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL period_unexpected: got a0=%0d a1=%0d a2=%0d b=%0d required no period",
                             acc_a0, acc_a1, acc_a2, acc_b);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_errors++;
                        $display("FAIL period_counts: got a0=%0d a1=%0d a2=%0d b=%0d required a0=%0d a1=%0d a2=%0d b=%0d",
                                 acc_a0, acc_a1, acc_a2, acc_b, exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
                    end
                end
                acc_a0 = 0;
                acc_a1 = 0;
                acc_a2 = 0;
                acc_b  = 0;
            end
            pd_armed = PERIOD_DONE;
            if (PERIOD_DONE) pd_total++;
        end
    end

    initial begin
        int pd_mark;
        INIT      = 1'b0;
        EN        = 1'b0;
        LD_VALID  = 1'b0;
        LD_IDX    = 2'd0;
        LD_DATA   = 8'd0;
        LD_COMMIT = 1'b0;

        // Reset and idle
        repeat (2) step();
        chk("rst_alpha", 32'(alpha), 0);
        chk("rst_beta", 32'(beta), 0);
        chk("rst_ready", 32'(LD_READY), 1);
        chk("rst_pd", 32'(PERIOD_DONE), 0);
        INIT = 1'b1;
        repeat (3) step();
        chk("idle_alpha", 32'(alpha), 0);
        chk("idle_beta", 32'(beta), 0);
        chk("idle_ready", 32'(LD_READY), 1);
        chk("idle_pd", 32'(PERIOD_DONE), 0);

        // Density: alpha={0,128,255}, beta=64, committed while stopped
        write_w(0, 0);
        write_w(1, 128);
        write_w(2, 255);
        write_w(3, 64);
        LD_COMMIT = 1'b1;
        step();
        LD_COMMIT = 1'b0;
        chk("stopped_commit_ready", 32'(LD_READY), 1);
        exp_q.push_back(pack4(0, 128, 255, 64));
        EN = 1'b1;
        pd_mark = pd_total;
        repeat (255) step();
        chk("p1_one_period_done", 32'(pd_total - pd_mark), 1);

        // Deferred commit at cycle 11; a write while pending must be dropped
        exp_q.push_back(pack4(0, 128, 255, 64));
        repeat (10) step();
        LD_VALID  = 1'b1;
        LD_IDX    = 2'd1;
        LD_DATA   = 8'd32;
        LD_COMMIT = 1'b1;
        step();
        LD_VALID  = 1'b0;
        LD_COMMIT = 1'b0;
        chk("p2_ready_pending", 32'(LD_READY), 0);
        repeat (38) step();
        write_w(0, 99);
        chk("p2_ready_still_pending", 32'(LD_READY), 0);
        repeat (204) step();
        chk("p2_ready_at_pd", 32'(LD_READY), 0);
        chk("p2_pd_pulse", 32'(PERIOD_DONE), 1);
        step();
        chk("p2_ready_after_pd", 32'(LD_READY), 1);
        chk("p2_pd_cleared", 32'(PERIOD_DONE), 0);

        // Freeze 20 cycles mid-period
        exp_q.push_back(pack4(0, 32, 255, 64));
        pd_mark = pd_total;
        repeat (100) step();
        EN = 1'b0;
        step();
        chk("frz_alpha", 32'(alpha), 0);
        chk("frz_beta", 32'(beta), 0);
        repeat (19) step();
        chk("frz_alpha_end", 32'(alpha), 0);
        chk("frz_pd", 32'(PERIOD_DONE), 0);
        EN = 1'b1;
        repeat (154) step();
        chk("p3_pd_after_resume", 32'(PERIOD_DONE), 1);
        step();
        chk("p3_one_period_done", 32'(pd_total - pd_mark), 1);
        EN = 1'b0;

        // Write and commit in the same stopped cycle
        LD_VALID  = 1'b1;
        LD_IDX    = 2'd2;
        LD_DATA   = 8'd7;
        LD_COMMIT = 1'b1;
        step();
        LD_VALID  = 1'b0;
        LD_COMMIT = 1'b0;
        chk("simul_ready", 32'(LD_READY), 1);
        exp_q.push_back(pack4(0, 32, 7, 64));
        EN = 1'b1;
        repeat (255) step();
        EN = 1'b0;

        // Reset while pending
        write_w(0, 200);
        EN        = 1'b1;
        LD_COMMIT = 1'b1;
        step();
        LD_COMMIT = 1'b0;
        chk("rp_ready_pending", 32'(LD_READY), 0);
        repeat (49) step();
        INIT = 1'b0;
        #2;
        chk("rp_ready", 32'(LD_READY), 1);
        chk("rp_alpha", 32'(alpha), 0);
        chk("rp_beta", 32'(beta), 0);
        chk("rp_pd", 32'(PERIOD_DONE), 0);
        EN = 1'b0;
        repeat (2) step();
        INIT = 1'b1;
        exp_q.push_back(pack4(0, 0, 0, 0));
        EN = 1'b1;
        repeat (255) step();
        EN = 1'b0;

        // EN drops while pending: beta 0 for 5 cycles, then 255 for 250 cycles
        write_w(3, 255);
        exp_q.push_back(pack4(0, 0, 0, 250));
        EN        = 1'b1;
        LD_COMMIT = 1'b1;
        step();
        LD_COMMIT = 1'b0;
        chk("drop_ready_pending", 32'(LD_READY), 0);
        repeat (4) step();
        EN = 1'b0;
        step();
        chk("drop_ready_open", 32'(LD_READY), 1);
        EN = 1'b1;
        repeat (250) step();
        EN = 1'b0;

        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
